// File: rtl/ethhelper_tap_pkg.sv
// Shared constants, trailer field layout and drain-state encoding for the AXI R-channel tap.
package ethhelper_tap_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Trailer layout from bit 0 upwards: stream type, worst response, beat count.
    // The latched ID occupies the top bits of the word.
    localparam int unsigned TYPE_OFFSET = 0;
    localparam int unsigned RESP_WIDTH  = 2;
    localparam int unsigned CNT_WIDTH   = 9;

    typedef enum logic {
        StData,
        StTrailer
    } drain_state_e;

endpackage

// File: rtl/r_capture_fifo.sv
// Synchronous FIFO for captured R beats; the head entry is read combinationally.
module r_capture_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr_q[AW-1:0]];
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/axi_r_stream_tap.sv
// AXI4 R-channel tap: forwards beats, buffers each accepted beat and drains them as a word
// stream, optionally closing every burst with a trailer (id, beat count, worst response).
module axi_r_stream_tap
    import ethhelper_tap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 128,
    parameter int unsigned ID_WIDTH          = 32,
    parameter int unsigned USER_WIDTH        = 64,
    parameter int unsigned FIFO_DEPTH        = 16,
    parameter bit          TRAILER_EN        = 1'b1,
    parameter int unsigned STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  can_forwardR,

    output logic [ID_WIDTH-1:0]   Fake_Sub_rid,
    output logic [DATA_WIDTH-1:0] Fake_Sub_rdata,
    output logic [1:0]            Fake_Sub_rresp,
    output logic                  Fake_Sub_rlast,
    output logic [USER_WIDTH-1:0] Fake_Sub_ruser,
    output logic                  Fake_Sub_rvalid,
    input  logic                  Fake_Sub_rready,

    input  logic [ID_WIDTH-1:0]   Real_Sub_rid,
    input  logic [DATA_WIDTH-1:0] Real_Sub_rdata,
    input  logic [1:0]            Real_Sub_rresp,
    input  logic                  Real_Sub_rlast,
    input  logic [USER_WIDTH-1:0] Real_Sub_ruser,
    input  logic                  Real_Sub_rvalid,
    output logic                  Real_Sub_rready,

    output logic                  output_valid,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_last,
    input  logic                  output_ready
);

    localparam int unsigned ENTRY_W  = DATA_WIDTH + ID_WIDTH + 3;
    localparam int unsigned RESP_OFF = TYPE_OFFSET + STREAM_TYPE_WIDTH;
    localparam int unsigned CNT_OFF  = RESP_OFF + RESP_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                  fwd_ok;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_wdata;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic [DATA_WIDTH-1:0] head_data;
    logic [ID_WIDTH-1:0]   head_id;
    logic [1:0]            head_resp;
    logic                  head_last;
    logic [DATA_WIDTH-1:0] trailer;

    drain_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]            resp_q, resp_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;

    // Reset is folded in so both handshake sides stay closed while resetn is low.
    assign fwd_ok          = resetn && can_forwardR && !fifo_full;
    assign Fake_Sub_rvalid = Real_Sub_rvalid && fwd_ok;
    assign Real_Sub_rready = Fake_Sub_rready && fwd_ok;
    assign push            = Real_Sub_rvalid && Real_Sub_rready;

    assign Fake_Sub_rid   = Real_Sub_rid;
    assign Fake_Sub_rdata = Real_Sub_rdata;
    assign Fake_Sub_rresp = Real_Sub_rresp;
    assign Fake_Sub_rlast = Real_Sub_rlast;
    assign Fake_Sub_ruser = Real_Sub_ruser;

    assign fifo_wdata = {Real_Sub_rdata, Real_Sub_rid, Real_Sub_rresp, Real_Sub_rlast};
    assign {head_data, head_id, head_resp, head_last} = fifo_rdata;

    r_capture_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (fifo_wdata),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        trailer = '0;
        trailer[TYPE_OFFSET +: STREAM_TYPE_WIDTH] = STREAM_TYPE;
        trailer[RESP_OFF +: RESP_WIDTH]           = resp_q;
        trailer[CNT_OFF +: CNT_WIDTH]             = cnt_q;
        trailer[DATA_WIDTH-1 -: ID_WIDTH]         = id_q;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_d       = resp_q;
        id_d         = id_q;
        pop          = 1'b0;
        output_valid = 1'b0;
        output_data  = '0;
        output_last  = 1'b0;

        unique case (state_q)
            StData: begin
                output_valid = !fifo_empty;
                // Gate the head so an empty FIFO never exposes stale storage.
                if (!fifo_empty) begin
                    output_data = head_data;
                    output_last = head_last && !TRAILER_EN;
                end
                if (output_valid && output_ready) begin
                    pop    = 1'b1;
                    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    resp_d = (head_resp > resp_q) ? head_resp : resp_q;
                    id_d   = head_id;
                    if (head_last) begin
                        if (TRAILER_EN) begin
                            state_d = StTrailer;
                        end else begin
                            cnt_d  = '0;
                            resp_d = RESP_OKAY;
                        end
                    end
                end
            end
            StTrailer: begin
                output_valid = 1'b1;
                output_last  = 1'b1;
                output_data  = trailer;
                if (output_ready) begin
                    state_d = StData;
                    cnt_d   = '0;
                    resp_d  = RESP_OKAY;
                end
            end
            default: state_d = StData;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StData;
            cnt_q   <= '0;
            resp_q  <= RESP_OKAY;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_axi_r_stream_tap.sv
// Directed bench for axi_r_stream_tap: one instance with trailers enabled, one without.
module tb_axi_r_stream_tap;

    logic         clk;
    logic         resetn;
    logic         can_forwardR;
    logic         f_rready;
    logic [31:0]  r_rid;
    logic [127:0] r_rdata;
    logic [1:0]   r_rresp;
    logic         r_rlast;
    logic [63:0]  r_ruser;
    logic         r_rvalid;
    logic         output_ready;

    logic [31:0]  f_rid1, f_rid2;
    logic [127:0] f_rdata1, f_rdata2;
    logic [1:0]   f_rresp1, f_rresp2;
    logic         f_rlast1, f_rlast2;
    logic [63:0]  f_ruser1, f_ruser2;
    logic         f_rvalid1, f_rvalid2;
    logic         real_rready1, real_rready2;
    logic         ov1, ov2;
    logic [127:0] od1, od2;
    logic         ol1, ol2;

    int n_checks = 0;
    int n_fails  = 0;

    axi_r_stream_tap #(
        .TRAILER_EN  (1'b1),
        .STREAM_TYPE (3'b101)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .can_forwardR    (can_forwardR),
        .Fake_Sub_rid    (f_rid1),
        .Fake_Sub_rdata  (f_rdata1),
        .Fake_Sub_rresp  (f_rresp1),
        .Fake_Sub_rlast  (f_rlast1),
        .Fake_Sub_ruser  (f_ruser1),
        .Fake_Sub_rvalid (f_rvalid1),
        .Fake_Sub_rready (f_rready),
        .Real_Sub_rid    (r_rid),
        .Real_Sub_rdata  (r_rdata),
        .Real_Sub_rresp  (r_rresp),
        .Real_Sub_rlast  (r_rlast),
        .Real_Sub_ruser  (r_ruser),
        .Real_Sub_rvalid (r_rvalid),
        .Real_Sub_rready (real_rready1),
        .output_valid    (ov1),
        .output_data     (od1),
        .output_last     (ol1),
        .output_ready    (output_ready)
    );

    axi_r_stream_tap #(
        .TRAILER_EN (1'b0)
    ) dut_notrl (
        .clk             (clk),
        .resetn          (resetn),
        .can_forwardR    (can_forwardR),
        .Fake_Sub_rid    (f_rid2),
        .Fake_Sub_rdata  (f_rdata2),
        .Fake_Sub_rresp  (f_rresp2),
        .Fake_Sub_rlast  (f_rlast2),
        .Fake_Sub_ruser  (f_ruser2),
        .Fake_Sub_rvalid (f_rvalid2),
        .Fake_Sub_rready (f_rready),
        .Real_Sub_rid    (r_rid),
        .Real_Sub_rdata  (r_rdata),
        .Real_Sub_rresp  (r_rresp),
        .Real_Sub_rlast  (r_rlast),
        .Real_Sub_ruser  (r_ruser),
        .Real_Sub_rvalid (r_rvalid),
        .Real_Sub_rready (real_rready2),
        .output_valid    (ov2),
        .output_data     (od2),
        .output_last     (ol2),
        .output_ready    (output_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] bd(input logic [31:0] id, input int i);
        logic [31:0] iv;
        iv = i;
        return {id, 32'hCAFE_0000 + iv, ~id, iv};
    endfunction

    // Trailer model for the STREAM_TYPE=3'b101 instance.
    function automatic logic [127:0] trl(input logic [31:0] id, input int cnt,
                                         input logic [1:0] resp);
        logic [127:0] t;
        logic [31:0]  c;
        c        = cnt;
        t        = '0;
        t[2:0]   = 3'b101;
        t[4:3]   = resp;
        t[13:5]  = c[8:0];
        t[127:96] = id;
        return t;
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input logic [31:0] id, input logic [127:0] d,
                             input logic [1:0] resp, input logic last);
        int n;
        n = 0;
        r_rid    = id;
        r_rdata  = d;
        r_rresp  = resp;
        r_rlast  = last;
        r_ruser  = {~id, id};
        r_rvalid = 1'b1;
        #1;
        while (!real_rready1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("send_timeout", 128'd0, 128'd1);
        @(posedge clk);
        @(negedge clk);
        r_rvalid = 1'b0;
    endtask

    // Called at a negedge; waits for a word on the chosen instance, checks it, then takes it.
    task automatic expect_word(input bit sel, input logic [127:0] exp_d, input logic exp_l,
                               input string tag);
        int n;
        n = 0;
        while (!(sel ? ov2 : ov1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check({tag, "_timeout"}, 128'd0, 128'd1);
        check({tag, "_data"}, sel ? od2 : od1, exp_d);
        check({tag, "_last"}, sel ? ol2 : ol1, exp_l);
        output_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        output_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk          = 1'b0;
        resetn       = 1'b0;
        can_forwardR = 1'b1;
        f_rready     = 1'b1;
        r_rid        = '0;
        r_rdata      = '0;
        r_rresp      = '0;
        r_rlast      = 1'b0;
        r_ruser      = '0;
        r_rvalid     = 1'b1;
        output_ready = 1'b0;

        // Reset state with a beat offered: both handshake sides closed.
        repeat (2) @(negedge clk);
        check("rst_ovalid", ov1, 1'b0);
        check("rst_odata", od1, 128'd0);
        check("rst_olast", ol1, 1'b0);
        check("rst_fvalid", f_rvalid1, 1'b0);
        check("rst_rready", real_rready1, 1'b0);
        r_rvalid = 1'b0;
        resetn   = 1'b1;
        @(negedge clk);

        // Single-beat burst with pass-through and latency checks.
        r_rid    = 32'h5;
        r_rdata  = {16{8'hA5}};
        r_rresp  = 2'b00;
        r_rlast  = 1'b1;
        r_ruser  = 64'h1234_5678_9ABC_DEF0;
        r_rvalid = 1'b1;
        #1;
        check("pt_rid", f_rid1, 32'h5);
        check("pt_rdata", f_rdata1, {16{8'hA5}});
        check("pt_rlast", f_rlast1, 1'b1);
        check("pt_ruser", f_ruser1, 64'h1234_5678_9ABC_DEF0);
        check("pt_fvalid", f_rvalid1, 1'b1);
        check("pt_rready", real_rready1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        r_rvalid = 1'b0;
        check("lat_ovalid", ov1, 1'b1);
        expect_word(1'b0, {16{8'hA5}}, 1'b0, "t1_word");
        expect_word(1'b0, trl(32'h5, 1, 2'b00), 1'b1, "t1_trl");
        check("t1_idle", ov1, 1'b0);

        // Four beats, second one SLVERR.
        for (int i = 0; i < 4; i++) send_beat(32'h7, bd(32'h7, i), (i == 1) ? 2'b10 : 2'b00, i == 3);
        for (int i = 0; i < 4; i++) expect_word(1'b0, bd(32'h7, i), 1'b0, "t2_word");
        expect_word(1'b0, trl(32'h7, 4, 2'b10), 1'b1, "t2_trl");

        // Fill to depth with the consumer stalled, then drain while the rest arrive.
        for (int i = 0; i < 16; i++) send_beat(32'h20, bd(32'h20, i), 2'b00, 1'b0);
        r_rid    = 32'h20;
        r_rdata  = bd(32'h20, 16);
        r_rlast  = 1'b0;
        r_rvalid = 1'b1;
        #1;
        check("full_rready", real_rready1, 1'b0);
        check("full_fvalid", f_rvalid1, 1'b0);
        @(negedge clk);
        r_rvalid = 1'b0;
        fork
            begin
                for (int i = 16; i < 20; i++) send_beat(32'h20, bd(32'h20, i), 2'b00, i == 19);
            end
            begin
                for (int i = 0; i < 20; i++) expect_word(1'b0, bd(32'h20, i), 1'b0, "t3_word");
                expect_word(1'b0, trl(32'h20, 20, 2'b00), 1'b1, "t3_trl");
            end
        join
        check("t3_idle", ov1, 1'b0);

        // can_forwardR low blocks new beats while buffered ones still drain.
        send_beat(32'h9, bd(32'h9, 0), 2'b01, 1'b0);
        send_beat(32'h9, bd(32'h9, 1), 2'b00, 1'b1);
        can_forwardR = 1'b0;
        r_rid        = 32'h99;
        r_rdata      = bd(32'h99, 0);
        r_rlast      = 1'b1;
        r_rvalid     = 1'b1;
        #1;
        check("cf_fvalid", f_rvalid1, 1'b0);
        check("cf_rready", real_rready1, 1'b0);
        @(negedge clk);
        expect_word(1'b0, bd(32'h9, 0), 1'b0, "t4_word0");
        expect_word(1'b0, bd(32'h9, 1), 1'b0, "t4_word1");
        expect_word(1'b0, trl(32'h9, 2, 2'b01), 1'b1, "t4_trl");
        repeat (3) @(negedge clk);
        check("cf_nocapture", ov1, 1'b0);
        r_rvalid     = 1'b0;
        can_forwardR = 1'b1;
        @(negedge clk);

        // Reset mid-burst: one beat consumed, three buffered.
        for (int i = 0; i < 4; i++) send_beat(32'h3, bd(32'h3, i), 2'b11, 1'b0);
        expect_word(1'b0, bd(32'h3, 0), 1'b0, "t5_pre");
        resetn = 1'b0;
        #1;
        check("mid_rst_ovalid", ov1, 1'b0);
        check("mid_rst_odata", od1, 128'd0);
        check("mid_rst_rready", real_rready1, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_empty", ov1, 1'b0);
        send_beat(32'h4, bd(32'h4, 0), 2'b00, 1'b0);
        send_beat(32'h4, bd(32'h4, 1), 2'b00, 1'b1);
        expect_word(1'b0, bd(32'h4, 0), 1'b0, "t5_word0");
        expect_word(1'b0, bd(32'h4, 1), 1'b0, "t5_word1");
        expect_word(1'b0, trl(32'h4, 2, 2'b00), 1'b1, "t5_trl");

        // Trailer-less instance: last on the final data word, nothing after.
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        send_beat(32'h6, bd(32'h6, 0), 2'b00, 1'b0);
        send_beat(32'h6, bd(32'h6, 1), 2'b10, 1'b1);
        expect_word(1'b1, bd(32'h6, 0), 1'b0, "t6_word0");
        expect_word(1'b1, bd(32'h6, 1), 1'b1, "t6_word1");
        check("t6_no_trl", ov2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
